preemphasis_ctrl: RTL and testbench

Sequencing controller for the acoustic front-end pre-emphasis filter. Drives the filter's enable, discards warm-up samples while the filter's one-sample history settles, then slices the filtered stream into fixed-length frames separated by an optional discarded gap. Emits registered frame-delimited output (`first_o`/`last_o`) for the downstream framing/FFT stage.

---
 rtl/aco_pkg.sv | 17 +
 rtl/sample_counter.sv | 38 +++
 rtl/preemphasis_ctrl.sv | 146 ++++++++++++++
 tb/tb_preemphasis_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aco_pkg.sv
// Shared types and defaults for the acoustic front-end sequencing logic.
package aco_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWarmup = 2'd1,
    StFrame  = 2'd2,
    StGap    = 2'd3
  } state_e;

  localparam int unsigned DBw          = 9;
  localparam int unsigned DefFrameLen  = 256;
  localparam int unsigned DefWarmupLen = 1;
  localparam int unsigned DefGapLen    = 0;
  localparam int unsigned DefCntBw     = 16;

endpackage

// File: rtl/sample_counter.sv
// Per-state sample counter: synchronous clear, increment on strobe, and an
// equality match against a limit supplied by the owner's current state.
module sample_counter #(
  parameter int unsigned CNT_BW = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic [CNT_BW-1:0] limit_i,
  output logic [CNT_BW-1:0] cnt_o,
  output logic              match_o
);

  logic [CNT_BW-1:0] cnt_d, cnt_q;

  // Clear wins over increment so a terminal sample restarts the count at 0.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_BW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign match_o = (cnt_q == limit_i);

endmodule

// File: rtl/preemphasis_ctrl.sv
// Sequences the pre-emphasis filter: enables it, drops warm-up samples, then
// slices the filtered stream into fixed frames with optional discarded gaps.
module preemphasis_ctrl
  import aco_pkg::*;
#(
  parameter int unsigned D_BW       = DBw,
  parameter int unsigned FRAME_LEN  = DefFrameLen,
  parameter int unsigned WARMUP_LEN = DefWarmupLen,
  parameter int unsigned GAP_LEN    = DefGapLen,
  parameter int unsigned CNT_BW     = DefCntBw
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  output logic                   pe_en_o,
  input  logic signed [D_BW-1:0] pe_data_i,
  input  logic                   pe_valid_i,
  output logic signed [D_BW-1:0] data_o,
  output logic                   valid_o,
  output logic                   first_o,
  output logic                   last_o,
  output logic [CNT_BW-1:0]      frame_cnt_o,
  output logic                   busy_o
);

  localparam logic [CNT_BW-1:0] WarmupLim = CNT_BW'(WARMUP_LEN - 1);
  localparam logic [CNT_BW-1:0] FrameLim  = CNT_BW'(FRAME_LEN - 1);
  localparam logic [CNT_BW-1:0] GapLim    = CNT_BW'(GAP_LEN - 1);
  localparam bit                HasGap    = (GAP_LEN != 0);

  state_e                 state_d, state_q;
  logic                   pe_en_d, pe_en_q;
  logic signed [D_BW-1:0] data_d, data_q;
  logic                   valid_d, valid_q;
  logic                   first_d, first_q;
  logic                   last_d, last_q;
  logic [CNT_BW-1:0]      frame_cnt_d, frame_cnt_q;

  logic              cnt_clr, cnt_inc, cnt_match;
  logic [CNT_BW-1:0] cnt, cnt_limit;

  always_comb begin
    cnt_limit = '0;
    unique case (state_q)
      StWarmup: cnt_limit = WarmupLim;
      StFrame:  cnt_limit = FrameLim;
      StGap:    cnt_limit = GapLim;
      default:  cnt_limit = '0;
    endcase
  end

  sample_counter #(
    .CNT_BW (CNT_BW)
  ) u_sample_counter (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .limit_i (cnt_limit),
    .cnt_o   (cnt),
    .match_o (cnt_match)
  );

  always_comb begin
    state_d     = state_q;
    pe_en_d     = pe_en_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    first_d     = 1'b0;
    last_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;

    // Disable overrides any sample arriving on the same cycle.
    if (!en_i) begin
      state_d = StIdle;
      pe_en_d = 1'b0;
      cnt_clr = 1'b1;
    end else begin
      pe_en_d = 1'b1;
      unique case (state_q)
        StIdle: begin
          state_d     = StWarmup;
          cnt_clr     = 1'b1;
          frame_cnt_d = '0;
        end
        StWarmup, StGap: begin
          if (pe_valid_i) begin
            if (cnt_match) begin
              state_d = StFrame;
              cnt_clr = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        StFrame: begin
          if (pe_valid_i) begin
            valid_d = 1'b1;
            data_d  = pe_data_i;
            first_d = (cnt == '0);
            last_d  = cnt_match;
            if (cnt_match) begin
              frame_cnt_d = frame_cnt_q + CNT_BW'(1);
              state_d     = HasGap ? StGap : StFrame;
              cnt_clr     = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      pe_en_q     <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pe_en_q     <= pe_en_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      first_q     <= first_d;
      last_q      <= last_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign pe_en_o     = pe_en_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign first_o     = first_q;
  assign last_o      = last_q;
  assign frame_cnt_o = frame_cnt_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_preemphasis_ctrl.sv
// Scoreboard bench: one instance with a 2-sample gap, one with back-to-back frames.
module tb_preemphasis_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vecs = 0;
  int miscompares = 0;

  // g: GAP_LEN=2, z: GAP_LEN=0
  logic              en_g = 1'b0, pv_g = 1'b0, en_z = 1'b0, pv_z = 1'b0;
  logic signed [8:0] pd_g = '0, pd_z = '0;
  logic              pe_en_g, valid_g, first_g, last_g, busy_g;
  logic              pe_en_z, valid_z, first_z, last_z, busy_z;
  logic signed [8:0] d_g, d_z;
  logic [15:0]       fc_g, fc_z;

  preemphasis_ctrl #(
    .D_BW (9), .FRAME_LEN (4), .WARMUP_LEN (1), .GAP_LEN (2), .CNT_BW (16)
  ) dut_g (
    .clk_i (clk), .rst_n_i (rst_n), .en_i (en_g), .pe_en_o (pe_en_g),
    .pe_data_i (pd_g), .pe_valid_i (pv_g), .data_o (d_g), .valid_o (valid_g),
    .first_o (first_g), .last_o (last_g), .frame_cnt_o (fc_g), .busy_o (busy_g)
  );

  preemphasis_ctrl #(
    .D_BW (9), .FRAME_LEN (4), .WARMUP_LEN (1), .GAP_LEN (0), .CNT_BW (16)
  ) dut_z (
    .clk_i (clk), .rst_n_i (rst_n), .en_i (en_z), .pe_en_o (pe_en_z),
    .pe_data_i (pd_z), .pe_valid_i (pv_z), .data_o (d_z), .valid_o (valid_z),
    .first_o (first_z), .last_o (last_z), .frame_cnt_o (fc_z), .busy_o (busy_z)
  );

  typedef struct {
    logic [8:0]  d;
    logic        f;
    logic        l;
    logic [15:0] fc;
    int          cyc;
  } exp_t;

  exp_t q_g[$];
  exp_t q_z[$];
  int   efc_g = 0;
  int   efc_z = 0;

  task automatic chk(input string name, input int act, input int req);
    vecs++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic mon_cmp(input string name, input exp_t e, input logic [8:0] d,
                         input logic f, input logic l, input logic [15:0] fc);
    vecs++;
    if (d !== e.d || f !== e.f || l !== e.l || fc !== e.fc || cyc != e.cyc) begin
      miscompares++;
      $display("FAIL %s: got d=%0d f=%0b l=%0b fc=%0d cyc=%0d, required d=%0d f=%0b l=%0b fc=%0d cyc=%0d",
               name, $signed(d), f, l, fc, cyc, $signed(e.d), e.f, e.l, e.fc, e.cyc);
    end
  endtask

  // Monitor: pops one expectation per output strobe, decoupled from the driver.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid_g) begin
        if (q_g.size() == 0) begin
          vecs++;
          miscompares++;
          $display("FAIL mon_g_unexpected: got valid_o=1 data=%0d, required no output", d_g);
        end else begin
          mon_cmp("mon_g", q_g.pop_front(), d_g, first_g, last_g, fc_g);
        end
      end
      if (valid_z) begin
        if (q_z.size() == 0) begin
          vecs++;
          miscompares++;
          $display("FAIL mon_z_unexpected: got valid_o=1 data=%0d, required no output", d_z);
        end else begin
          mon_cmp("mon_z", q_z.pop_front(), d_z, first_z, last_z, fc_z);
        end
      end
    end
  end

  // code: 0 dropped, 1 first, 2 middle, 3 last
  task automatic send(input bit z, input int v, input int gap, input int code);
    exp_t e;
    if (code != 0) begin
      if (code == 3) begin
        if (z) efc_z++; else efc_g++;
      end
      e.d   = v[8:0];
      e.f   = (code == 1);
      e.l   = (code == 3);
      e.fc  = z ? efc_z[15:0] : efc_g[15:0];
      e.cyc = cyc + 1;
      if (z) q_z.push_back(e); else q_g.push_back(e);
    end
    if (z) begin pd_z = v[8:0]; pv_z = 1'b1; end
    else   begin pd_g = v[8:0]; pv_g = 1'b1; end
    @(posedge clk); #1;
    pv_g = 1'b0;
    pv_z = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic enable_g();
    en_g = 1'b1;
    @(posedge clk); #1;
    efc_g = 0;
    chk("en_pe_en", int'(pe_en_g), 1);
    chk("en_busy", int'(busy_g), 1);
    chk("en_frame_cnt", int'(fc_g), 0);
  endtask

  task automatic disable_g();
    en_g = 1'b0;
    @(posedge clk); #1;
    chk("dis_pe_en", int'(pe_en_g), 0);
    chk("dis_busy", int'(busy_g), 0);
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_q_g_empty"}, q_g.size(), 0);
    chk({name, "_q_z_empty"}, q_z.size(), 0);
  endtask

  int s16[16] = '{0, 1, 2, 2, 3, 0, 0, 1, 2, 2, 3, 0, 0, 1, 2, 2};
  int s9[9]   = '{0, 1, 2, 2, 3, 1, 2, 2, 3};
  int s5[5]   = '{0, 1, 2, 2, 3};

  initial begin
    // Reset values.
    #2;
    chk("rst_pe_en", int'(pe_en_g), 0);
    chk("rst_valid", int'(valid_g), 0);
    chk("rst_data", int'(d_g), 0);
    chk("rst_first", int'(first_g), 0);
    chk("rst_last", int'(last_g), 0);
    chk("rst_frame_cnt", int'(fc_g), 0);
    chk("rst_busy", int'(busy_g), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", int'(busy_g), 0);

    // Scenario 1: back-to-back samples 1..16.
    enable_g();
    for (int i = 0; i < 16; i++) send(1'b0, i + 1, 0, s16[i]);
    drain("s1");
    chk("s1_frame_cnt", int'(fc_g), 2);
    disable_g();

    // Scenario 2: a sample every third cycle.
    enable_g();
    for (int i = 0; i < 16; i++) send(1'b0, i + 1, 2, s16[i]);
    drain("s2");
    chk("s2_frame_cnt", int'(fc_g), 2);
    disable_g();

    // Scenario 3: no gap between frames.
    en_z = 1'b1;
    @(posedge clk); #1;
    chk("s3_busy", int'(busy_z), 1);
    for (int i = 0; i < 9; i++) send(1'b1, i + 1, 0, s9[i]);
    drain("s3");
    chk("s3_frame_cnt", int'(fc_z), 2);
    en_z = 1'b0;

    // Scenario 4: disable after 2nd sample of 2nd frame, with a coincident sample.
    enable_g();
    for (int i = 0; i < 9; i++) send(1'b0, i + 1, 0, s16[i]);
    en_g = 1'b0;
    pd_g = 9'sd10;
    pv_g = 1'b1;
    @(posedge clk); #1;
    pv_g = 1'b0;
    chk("s4_pe_en", int'(pe_en_g), 0);
    chk("s4_busy", int'(busy_g), 0);
    chk("s4_valid", int'(valid_g), 0);
    drain("s4a");
    enable_g();
    for (int i = 0; i < 5; i++) send(1'b0, i + 1, 0, s5[i]);
    drain("s4b");
    chk("s4_frame_cnt", int'(fc_g), 1);
    disable_g();

    // Scenario 5: asynchronous reset while valid_o is high mid-frame.
    enable_g();
    for (int i = 0; i < 3; i++) send(1'b0, i + 1, 0, s16[i]);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_pe_en", int'(pe_en_g), 0);
    chk("s5_valid", int'(valid_g), 0);
    chk("s5_data", int'(d_g), 0);
    chk("s5_first", int'(first_g), 0);
    chk("s5_busy", int'(busy_g), 0);
    chk("s5_q_empty", q_g.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    efc_g = 0;
    chk("s5_busy_again", int'(busy_g), 1);
    for (int i = 0; i < 16; i++) send(1'b0, i + 1, 0, s16[i]);
    drain("s5");
    chk("s5_frame_cnt", int'(fc_g), 2);
    disable_g();

    // Scenario 6: data extremes pass through unchanged.
    enable_g();
    send(1'b0, 1, 0, 0);
    send(1'b0, -256, 0, 1);
    send(1'b0, 255, 0, 2);
    send(1'b0, -1, 0, 2);
    send(1'b0, 0, 0, 3);
    drain("s6");
    disable_g();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
